idex_skid_stage: RTL and testbench
==================================

Name: idex_skid_stage

Overview:
- Parametrised ID/EX pipeline boundary with a valid/ready handshake and a two-entry skid buffer.
- Decode can keep presenting beats while execute stalls, and no combinational path exists from out_ready to in_ready.
- Carries operand, immediate, PC, control and register-index fields, with synchronous flush for branch/hazard squash.
- Includes a saturating bubble counter for performance monitoring.

Parameters:
XLEN, 64, width of PC, operand and immediate fields
CTRL_W, 8, packed control bits (Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp[1:0])
REG_AW, 5, register index width
FUNCT_W, 4, funct field width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  squash all held beats; synchronous
in_valid  in  1  decode presents a beat
in_ready  out  1  stage can accept a beat
in_pc, in_rdata1, in_rdata2, in_imm  in  XLEN each  payload from decode
in_ctrl  in  CTRL_W  control bits
in_rd, in_rs1, in_rs2  in  REG_AW each  register indices
in_funct  in  FUNCT_W  funct field
out_valid  out  1  beat available to execute
out_ready  in  1  execute consumes beat
out_pc, out_rdata1, out_rdata2, out_imm  out  XLEN each  payload to execute
out_ctrl  out  CTRL_W  control bits, gated with out_valid
out_rd, out_rs1, out_rs2  out  REG_AW each  register indices
out_funct  out  FUNCT_W  funct field
bubble_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Storage and outputs:
  - Two entries: main (drives out_*) and skid. Each entry holds the full payload and a valid bit.
  - Handshake fires when valid & ready are both high on a rising edge.
- States, encoded from the valid bits:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- Port decode:
  - in_ready = (state != FULL); this is a pure function of registered state.
  - out_valid = main valid.
- Transitions, when flush=0:
  - EMPTY, in_valid=1: main <= in, go to ONE. Otherwise stay.
  - ONE, in_valid=1 and out_ready=1: main <= in, stay in ONE (full throughput, 1 beat/cycle).
  - ONE, in_valid=1 and out_ready=0: skid <= in, go to FULL.
  - ONE, in_valid=0 and out_ready=1: go to EMPTY. Main payload is retained but masked.
  - ONE, in_valid=0 and out_ready=0: hold.
  - FULL, out_ready=1: main <= skid, go to ONE. in_valid is ignored because in_ready=0.
  - FULL, out_ready=0: hold.
- Latency: 1 cycle from an accepted input to out_valid when the stage was EMPTY. Order is strictly FIFO.
- out_ctrl masking:
  - out_ctrl = main ctrl AND out_valid, so a bubble presents all-zero control (NOP: no RegWrite, MemWrite or Branch).
  - Other out_* fields are unmasked.
- Flush:
  - Next state is EMPTY.
  - Both entries' valid bits and ctrl fields are cleared to 0, and all payload registers are cleared to 0.
  - Flush wins over a simultaneous input handshake; that input beat is dropped.
  - Flush wins over a simultaneous output handshake; the output beat is still considered consumed by the downstream stage.
- Reset:
  - Highest priority over flush and handshakes, and is synchronous.
  - All registers go to 0 and the state goes to EMPTY.
  - Outputs after reset: out_valid=0, in_ready=1, every out_* = 0, bubble_cnt = 0.
  - A reset asserted mid-stall (FULL) discards both beats.
- Bubble counter:
  - Increments by 1 on each cycle with out_valid=0, out_ready=1 and reset=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Flush does not clear it; only reset does.
- Interface rules:
  - in_* payload is sampled only on an input handshake.
  - Held payload is stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then idle: reset high 2 cycles, then low -> out_valid=0, in_ready=1, all out_*=0, out_ctrl=0; with out_ready=1, bubble_cnt counts 1, 2, 3 on successive cycles.
- Streaming: out_ready=1, in_valid=1 for 4 beats with in_pc=0x100, 0x104, 0x108, 0x10C -> out_pc shows the same sequence one cycle later, out_valid=1 each cycle, in_ready stays 1.
- Backpressure/skid:
  - Stimulus: beat A (pc 0x200) accepted; out_ready=0; beat B (pc 0x204) presented.
  - Response: B goes to skid, in_ready=0, out_pc holds 0x200.
  - Release: raise out_ready -> 0x200 then 0x204 delivered, in_ready returns to 1; beat C held on in_* while in_ready=0 is accepted only afterwards, with no loss or duplication.
- Flush in FULL:
  - Stimulus: FULL with ctrl=0xFF; assert flush together with in_valid=1 (pc 0x300).
  - Response: next cycle out_valid=0, out_ctrl=0, out_pc=0, in_ready=1; beat 0x300 never appears.
- Control masking: beat with ctrl=0x24 drains, no new input, out_ready=1 -> out_valid=0 and out_ctrl=0 while out_rd retains its last value.
- Reset dominance and saturation:
  - Reset asserted with flush and in_valid in FULL -> all zero, EMPTY.
  - With CNT_W=3, hold idle with out_ready=1 for 10 cycles -> bubble_cnt stops at 7.

Source files
------------

// File: rtl/idex_skid_stage.sv
// ID/EX pipeline register with a two-entry skid buffer, flush squash and a
// saturating bubble counter. in_ready depends only on registered state.
module idex_skid_stage #(
  parameter int XLEN    = 64,
  parameter int CTRL_W  = 8,
  parameter int REG_AW  = 5,
  parameter int FUNCT_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,

  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_rdata1,
  input  logic [XLEN-1:0]    in_rdata2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic [REG_AW-1:0]  in_rs1,
  input  logic [REG_AW-1:0]  in_rs2,
  input  logic [FUNCT_W-1:0] in_funct,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_rdata1,
  output logic [XLEN-1:0]    out_rdata2,
  output logic [XLEN-1:0]    out_imm,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [REG_AW-1:0]  out_rd,
  output logic [REG_AW-1:0]  out_rs1,
  output logic [REG_AW-1:0]  out_rs2,
  output logic [FUNCT_W-1:0] out_funct,

  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rdata1;
    logic [XLEN-1:0]    rdata2;
    logic [XLEN-1:0]    imm;
    logic [CTRL_W-1:0]  ctrl;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic [FUNCT_W-1:0] funct;
  } payload_t;

  // State bits are exactly {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t     state_reg, state_next;
  payload_t   main_reg, main_next;
  payload_t   skid_reg, skid_next;
  payload_t   in_beat;
  logic       main_valid;
  logic [CNT_W-1:0] bubble_reg, bubble_next;

  assign in_beat.pc     = in_pc;
  assign in_beat.rdata1 = in_rdata1;
  assign in_beat.rdata2 = in_rdata2;
  assign in_beat.imm    = in_imm;
  assign in_beat.ctrl   = in_ctrl;
  assign in_beat.rd     = in_rd;
  assign in_beat.rs1    = in_rs1;
  assign in_beat.rs2    = in_rs2;
  assign in_beat.funct  = in_funct;

  assign main_valid = state_reg[0];
  assign in_ready   = (state_reg != ST_FULL);
  assign out_valid  = main_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_EMPTY;
      main_reg   <= '0;
      skid_reg   <= '0;
      bubble_reg <= '0;
    end else begin
      state_reg  <= state_next;
      main_reg   <= main_next;
      skid_reg   <= skid_next;
      bubble_reg <= bubble_next;
    end
  end

  // Flush clears every held field so a squashed beat leaves no trace.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = ST_EMPTY;
      main_next  = '0;
      skid_next  = '0;
    end else begin
      unique case (state_reg)
        ST_EMPTY: begin
          if (in_valid) begin
            main_next  = in_beat;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            main_next = in_beat;
          end else if (in_valid) begin
            skid_next  = in_beat;
            state_next = ST_FULL;
          end else if (out_ready) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            main_next  = skid_reg;
            state_next = ST_ONE;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    bubble_next = bubble_reg;
    if (!main_valid && out_ready && (bubble_reg != {CNT_W{1'b1}})) begin
      bubble_next = bubble_reg + CNT_W'(1);
    end
  end

  assign bubble_cnt = bubble_reg;

  // A bubble must present NOP control even though the payload is retained.
  for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
    assign out_ctrl[gi] = main_reg.ctrl[gi] & main_valid;
  end

  assign out_pc     = main_reg.pc;
  assign out_rdata1 = main_reg.rdata1;
  assign out_rdata2 = main_reg.rdata2;
  assign out_imm    = main_reg.imm;
  assign out_rd     = main_reg.rd;
  assign out_rs1    = main_reg.rs1;
  assign out_rs2    = main_reg.rs2;
  assign out_funct  = main_reg.funct;

endmodule

// File: tb/tb_idex_skid_stage.sv
// Scoreboard bench for idex_skid_stage: driver pushes accepted beats, a
// negedge monitor pops and compares each delivered beat.
module tb_idex_skid_stage;
  localparam int XLEN    = 64;
  localparam int CTRL_W  = 8;
  localparam int REG_AW  = 5;
  localparam int FUNCT_W = 4;
  localparam int CNT_W   = 3;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0]    in_pc, in_rdata1, in_rdata2, in_imm;
  logic [XLEN-1:0]    out_pc, out_rdata1, out_rdata2, out_imm;
  logic [CTRL_W-1:0]  in_ctrl, out_ctrl;
  logic [REG_AW-1:0]  in_rd, in_rs1, in_rs2, out_rd, out_rs1, out_rs2;
  logic [FUNCT_W-1:0] in_funct, out_funct;
  logic [CNT_W-1:0]   bubble_cnt;

  always #5 clk = ~clk;

  idex_skid_stage #(
    .XLEN(XLEN), .CTRL_W(CTRL_W), .REG_AW(REG_AW), .FUNCT_W(FUNCT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct(in_funct),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct(out_funct), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic [XLEN-1:0]    pc, rdata1, rdata2, imm;
    logic [CTRL_W-1:0]  ctrl;
    logic [REG_AW-1:0]  rd, rs1, rs2;
    logic [FUNCT_W-1:0] funct;
  } beat_t;

  beat_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [XLEN-1:0] pc, input logic [CTRL_W-1:0] ctrl,
                               input logic [REG_AW-1:0] rd);
    beat_t b;
    b.pc     = pc;
    b.rdata1 = pc + 64'h1000;
    b.rdata2 = pc + 64'h2000;
    b.imm    = pc + 64'h30;
    b.ctrl   = ctrl;
    b.rd     = rd;
    b.rs1    = rd + 5'd1;
    b.rs2    = rd + 5'd2;
    b.funct  = pc[5:2];
    return b;
  endfunction

  task automatic drive(input beat_t b);
    in_pc = b.pc; in_rdata1 = b.rdata1; in_rdata2 = b.rdata2; in_imm = b.imm;
    in_ctrl = b.ctrl; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2; in_funct = b.funct;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the beat on in_* until the stage accepts it; returns at posedge+1.
  task automatic send(input beat_t b);
    drive(b);
    in_valid = 1'b1;
    for (int t = 0; t <= 50; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t == 50) begin
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: in_ready=%0b for pc 0x%0h, required 1", in_ready, b.pc);
      end
    end
    @(posedge clk);
    sb.push_back(b);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    beat_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_beat: got pc 0x%0h, required no beat", out_pc);
      end else begin
        e = sb.pop_front();
        $display("beat pc=0x%0h rd=%0d ctrl=0x%0h", out_pc, out_rd, out_ctrl);
        check("out_pc", out_pc, e.pc);
        check("out_rdata1", out_rdata1, e.rdata1);
        check("out_rdata2", out_rdata2, e.rdata2);
        check("out_imm", out_imm, e.imm);
        check("out_ctrl", out_ctrl, e.ctrl);
        check("out_rd", out_rd, e.rd);
        check("out_rs1", out_rs1, e.rs1);
        check("out_rs2", out_rs2, e.rs2);
        check("out_funct", out_funct, e.funct);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(64'h0, 8'h0, 5'd0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, then idle bubble counting
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_bubble", bubble_cnt, 0);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      check("idle_bubble", bubble_cnt, k);
    end

    // Streaming at full throughput
    tick();
    for (int i = 0; i < 4; i++) begin
      send(mk(64'h100 + 64'(4 * i), 8'h10 + 8'(i), 5'(i + 1)));
    end
    @(negedge clk);
    check("stream_in_ready", in_ready, 1);
    tick();

    // Backpressure into the skid entry
    out_ready = 1'b0;
    send(mk(64'h200, 8'h22, 5'd3));
    send(mk(64'h204, 8'h23, 5'd4));
    @(negedge clk);
    check("skid_in_ready", in_ready, 0);
    check("skid_out_valid", out_valid, 1);
    check("skid_out_pc", out_pc, 64'h200);
    @(negedge clk);
    check("skid_hold_pc", out_pc, 64'h200);
    fork
      send(mk(64'h208, 8'h21, 5'd5));
      begin
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    check("release_sb_empty", sb.size(), 0);

    // Flush while FULL, with a simultaneous input beat
    tick();
    out_ready = 1'b0;
    send(mk(64'h280, 8'hFF, 5'd6));
    send(mk(64'h284, 8'hFF, 5'd7));
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_ctrl", out_ctrl, 8'hFF);
    tick();
    drive(mk(64'h300, 8'hFF, 5'd8));
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_ctrl", out_ctrl, 0);
    check("flush_out_pc", out_pc, 0);
    check("flush_out_rd", out_rd, 0);
    check("flush_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("flush_no_beat", out_valid, 0);

    // Flush in ONE drops an accepted-looking input beat
    tick();
    out_ready = 1'b0;
    send(mk(64'h2C0, 8'h33, 5'd9));
    drive(mk(64'h2C4, 8'h34, 5'd10));
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush1_out_valid", out_valid, 0);
    check("flush1_out_pc", out_pc, 0);
    tick();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("flush1_no_beat", out_valid, 0);

    // Control masking on a bubble
    tick();
    send(mk(64'h400, 8'h24, 5'd17));
    @(negedge clk);
    @(negedge clk);
    check("mask_out_valid", out_valid, 0);
    check("mask_out_ctrl", out_ctrl, 0);
    check("mask_out_rd", out_rd, 17);
    check("mask_out_pc", out_pc, 64'h400);

    // Reset dominates flush and input in FULL; then saturation
    tick();
    out_ready = 1'b0;
    send(mk(64'h500, 8'h55, 5'd11));
    send(mk(64'h504, 8'h56, 5'd12));
    drive(mk(64'h508, 8'h57, 5'd13));
    in_valid = 1'b1;
    flush = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_out_pc", out_pc, 0);
    check("rst2_out_ctrl", out_ctrl, 0);
    check("rst2_out_rd", out_rd, 0);
    check("rst2_bubble", bubble_cnt, 0);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      check("sat_bubble", bubble_cnt, (k > 7) ? 7 : k);
    end

    check("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
